bcd_serial_add_ctrl: RTL and testbench
======================================

# bcd_serial_add_ctrl

Digit-serial controller for multi-digit packed-BCD addition. It accepts two DIGITS-wide BCD operands and a carry-in through a start/ready handshake. It sequences one shared single-digit BCD adder slice over the digits, least-significant first, with the inter-digit carry held in a register. It then presents the sum, carry-out and an error flag with a one-cycle done pulse. It sits between a host request port and the BCD arithmetic datapath, replacing the free-running single-digit adder/carry pair with a sequenced, handshaken operation.

## Interface
- DIGITS, default 4: number of BCD digits per operand, minimum 1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when ready=1.
- abort  input  1  synchronous cancel of an operation in progress.
- a  input  4*DIGITS  operand A, packed BCD; digit i at bits [4i+3:4i].
- b  input  4*DIGITS  operand B, same packing as a.
- cin  input  1  carry into digit 0.
- ready  output  1  high in IDLE only.
- busy  output  1  high in ADD only.
- done  output  1  one-cycle pulse in DONE.
- sum  output  4*DIGITS  BCD result; packing as a.
- cout  output  1  carry out of digit DIGITS-1.
- err  output  1  at least one operand digit was greater than 9.

## Operation
- **Reset values:** FSM in IDLE, ready=1, busy=0, done=0, sum=0, cout=0, err=0. The internal digit index, carry, operand and work registers are all cleared.
- **FSM states:** IDLE, ADD, DONE.
- **IDLE:**
  - On start=1, latch a, b and cin, set index=0, and go to ADD.
  - abort has no effect in IDLE.
- **ADD:** each cycle processes digit `index`:
  - Compute t = a_d + b_d + carry as a 5-bit value (range 0..31).
  - If t > 9: digit = (t + 6)[3:0] and carry_next = 1.
  - Otherwise: digit = t[3:0] and carry_next = 0.
  - Write the digit into the work register at position `index`.
  - Set the err accumulator if a_d > 9 or b_d > 9.
  - Increment index.
  - When index = DIGITS-1 is processed, go to DONE.
  - Invalid digits are still computed by this exact rule; the result is defined but not meaningful.
- **DONE:**
  - sum, cout and err are loaded from the work register, the final carry and the err accumulator on the edge that enters DONE.
  - done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- **Output hold:** sum, cout and err hold their values from the DONE entry until the next DONE entry. They never change during ADD, and reset clears them.
- **start while not IDLE:** ignored and not queued.
- **abort=1 in ADD:** return to IDLE on the next edge. No done pulse is produced, sum/cout/err keep their previous values, and the work state is discarded.
- **abort=1 in DONE:** ignored; the pulse completes.
- **Asynchronous rst mid-operation:** immediate return to IDLE with all reset values; no done pulse.

## Timing
- Edge numbering: start is accepted at edge k.
- busy=1 from after edge k through edge k+DIGITS.
- Digit i is processed at edge k+1+i.
- The state enters DONE at edge k+DIGITS. done is high, with valid sum/cout/err, during the cycle between edges k+DIGITS and k+DIGITS+1.
- ready returns high after edge k+DIGITS+1. A new start is accepted at that edge at the earliest.
- Throughput: one operation per DIGITS+1 cycles.
- DIGITS=1 is legal: ADD lasts one cycle.
- ready, busy and done are mutually exclusive and exactly one is high in every cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic add:** DIGITS=4, a=0x1234, b=0x5678, cin=0. Required: done exactly 4 cycles after the start edge, sum=0x6912, cout=0, err=0, and ready high the following cycle.
- **Full ripple carry:** a=0x9999, b=0x0001, cin=0. Required: sum=0x0000, cout=1. Then a=0x0000, b=0x0000, cin=1. Required: sum=0x0001, cout=0.
- **Invalid digit:** a=0x00A0, b=0x0000, cin=0. Required: err=1, sum=0x0100, cout=0 (t=10 gives digit 0 and carry 1). A following valid operation must clear err to 0.
- **Start ignored when busy:** pulse start again 2 cycles into an operation with different operands. Required: the first result is unchanged, exactly one done pulse occurs, and no second operation runs.
- **Abort:** assert abort in the second ADD cycle. Required: ready=1 next cycle, no done pulse, and sum/cout/err still hold the previous result. A new start afterwards completes normally.
- **Reset mid-ADD:** assert rst asynchronously mid-operation. Required: outputs go immediately to ready=1, busy=0, done=0, sum=0, cout=0, err=0, and no done pulse follows.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one shared digit slice stepped LSD-first
// under a start/ready handshake, with registered sum/cout/err and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// ADD   | one digit per cycle, index 0..DIGITS-1; busy=1
// DONE  | results just loaded; done=1 for one cycle
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [IW-1:0]   index;
   logic            carry;
   logic            err_acc;
   logic [W-1:0]    op_a, op_b, work;

   logic [3:0]      a_d, b_d, digit;
   logic [4:0]      t, t_adj;
   logic            carry_next, err_next, last;
   logic [W-1:0]    work_next;

   assign ready = (state == IDLE);
   assign busy  = (state == ADD);
   assign done  = (state == DONE);

   // Shared single-digit BCD slice acting on the digit selected by index
   always_comb begin
      a_d        = op_a[4*index +: 4];
      b_d        = op_b[4*index +: 4];
      t          = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry};
      t_adj      = t + 5'd6;
      carry_next = (t > 5'd9);
      digit      = carry_next ? t_adj[3:0] : t[3:0];
      err_next   = err_acc | (a_d > 4'd9) | (b_d > 4'd9);
      work_next  = work;
      work_next[4*index +: 4] = digit;
      last       = (index == LAST_IDX);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = ADD;
         ADD: begin
            if (abort)     state_next = IDLE;
            else if (last) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index   <= '0;
         carry   <= 1'b0;
         err_acc <= 1'b0;
         op_a    <= '0;
         op_b    <= '0;
         work    <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_a    <= a;
                  op_b    <= b;
                  carry   <= cin;
                  index   <= '0;
                  work    <= '0;
                  err_acc <= 1'b0;
               end
            end
            ADD: begin
               if (abort) begin
                  index   <= '0;
                  carry   <= 1'b0;
                  err_acc <= 1'b0;
                  work    <= '0;
               end else begin
                  work    <= work_next;
                  carry   <= carry_next;
                  err_acc <= err_next;
                  index   <= index + 1'b1;
                  // Results are published on the edge that enters DONE
                  if (last) begin
                     sum  <= work_next;
                     cout <= carry_next;
                     err  <= err_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl with DIGITS=4 and
// hand-computed BCD results.
module tb_bcd_serial_add_ctrl;

   localparam int DIGITS = 4;
   localparam int W = 4 * DIGITS;

   logic         clk = 1'b0;
   logic         rst, start, abort, cin;
   logic [W-1:0] a, b, sum;
   logic         ready, busy, done, cout, err;

   int checks = 0;
   int errors = 0;

   bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a(a), .b(b), .cin(cin),
      .ready(ready), .busy(busy), .done(done),
      .sum(sum), .cout(cout), .err(err)
   );

   always #5 clk = ~clk;

   // exactly one of ready/busy/done in every cycle
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if ((ready + busy + done) !== 2'd1) begin
            errors++;
            $display("FAIL onehot_status: ready=%b busy=%b done=%b required exactly one high",
                     ready, busy, done);
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the start-accept edge
   task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
      a = ta; b = tb; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Cycles from the start-accept edge until done is seen; 20 means timeout
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;
      #3;
      checks++;
      if ({ready, busy, done, sum, cout, err} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got ready=%b busy=%b done=%b sum=%h cout=%b err=%b required 1 0 0 0000 0 0",
                  ready, busy, done, sum, cout, err);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int n;
      do_start(16'h1234, 16'h5678, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL basic_busy: got busy=%b required 1", busy);
      end
      wait_done(n);
      checks++;
      if (n !== 4) begin
         errors++; $display("FAIL basic_latency: got %0d cycles required 4", n);
      end
      checks++;
      if ({sum, cout, err} !== {16'h6912, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_result: got sum=%h cout=%b err=%b required 6912 0 0", sum, cout, err);
      end
      @(posedge clk); #1;
      checks++;
      if ({ready, done} !== 2'b10) begin
         errors++; $display("FAIL basic_ready_after: got ready=%b done=%b required 1 0", ready, done);
      end
   endtask

   task automatic test_ripple;
      int n;
      do_start(16'h9999, 16'h0001, 1'b0);
      wait_done(n);
      checks++;
      if ({n == 4, sum, cout, err} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL ripple_9999: got cycles=%0d sum=%h cout=%b err=%b required 4 0000 1 0",
                  n, sum, cout, err);
      end
      @(posedge clk); #1;
      do_start(16'h0000, 16'h0000, 1'b1);
      wait_done(n);
      checks++;
      if ({n == 4, sum, cout, err} !== {1'b1, 16'h0001, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL ripple_cin: got cycles=%0d sum=%h cout=%b err=%b required 4 0001 0 0",
                  n, sum, cout, err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_invalid;
      int n;
      do_start(16'h00A0, 16'h0000, 1'b0);
      wait_done(n);
      checks++;
      if ({n == 4, sum, cout, err} !== {1'b1, 16'h0100, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL invalid_digit: got cycles=%0d sum=%h cout=%b err=%b required 4 0100 0 1",
                  n, sum, cout, err);
      end
      @(posedge clk); #1;
      do_start(16'h0042, 16'h0058, 1'b0);
      wait_done(n);
      checks++;
      if ({n == 4, sum, cout, err} !== {1'b1, 16'h0100, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL invalid_clear: got cycles=%0d sum=%h cout=%b err=%b required 4 0100 0 0",
                  n, sum, cout, err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored;
      int ndone = 0;
      int busy_after = 0;
      do_start(16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      a = 16'h4444; b = 16'h4444; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) begin
            ndone++;
            checks++;
            if ({sum, cout, err} !== {16'h3333, 1'b0, 1'b0}) begin
               errors++;
               $display("FAIL ignored_result: got sum=%h cout=%b err=%b required 3333 0 0", sum, cout, err);
            end
         end else if (ndone > 0 && busy === 1'b1) begin
            busy_after++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (ndone !== 1) begin
         errors++; $display("FAIL ignored_done_count: got %0d pulses required 1", ndone);
      end
      checks++;
      if (busy_after !== 0) begin
         errors++; $display("FAIL ignored_second_op: got %0d busy cycles after done required 0", busy_after);
      end
   endtask

   task automatic test_abort;
      int n;
      int ndone = 0;
      do_start(16'h5555, 16'h1111, 1'b0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL abort_ready: got ready=%b busy=%b done=%b required 1 0 0", ready, busy, done);
      end
      checks++;
      if ({sum, cout, err} !== {16'h3333, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort_hold: got sum=%h cout=%b err=%b required 3333 0 0", sum, cout, err);
      end
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      checks++;
      if (ndone !== 0) begin
         errors++; $display("FAIL abort_no_done: got %0d pulses required 0", ndone);
      end
      do_start(16'h0005, 16'h0005, 1'b0);
      wait_done(n);
      checks++;
      if ({n == 4, sum, cout, err} !== {1'b1, 16'h0010, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort_restart: got cycles=%0d sum=%h cout=%b err=%b required 4 0010 0 0",
                  n, sum, cout, err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int ndone = 0;
      do_start(16'h9999, 16'h9999, 1'b1);
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ready, busy, done, sum, cout, err} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got ready=%b busy=%b done=%b sum=%h cout=%b err=%b required 1 0 0 0000 0 0",
                  ready, busy, done, sum, cout, err);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      checks++;
      if ({ndone == 0, ready} !== 2'b11) begin
         errors++; $display("FAIL reset_mid_no_done: got %0d pulses ready=%b required 0 1", ndone, ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ripple();
      test_invalid();
      test_start_ignored();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
